// File: rtl/gpu_clut_slot_cache.sv
// ---------------------------------------------------------------------------
// gpu_clut_slot_cache
//
// Multi-slot CLUT cache controller for the GPU texture path. Tracks up to
// NUM_SLOTS resident palettes by VRAM CLUT address and depth (4bpp / 8bpp).
// On a miss, or when a 4bpp-resident palette is requested as 8bpp (upgrade),
// it streams palette blocks from VRAM into the chosen slot.
//
// Ports
//   i_clk          clock
//   i_rstGPU       asynchronous active-high reset
//   i_flush        synchronous invalidate of all slots, aborts any load
//   i_clutReq      palette request (accepted only while o_busy=0)
//   i_clutAdr      CLUT word: [14:6] row/X-high, [5:0] X block base
//   i_clutIs8BPP   requested depth is 8bpp (else 4bpp)
//   o_busy         load in progress; requests are dropped while high
//   o_ready        one-cycle pulse: requested palette is resident in o_slot
//   o_slot         slot holding the current palette
//   o_memReq       block fetch request
//   o_memAdr       VRAM block address of the current fetch
//   i_memAck       block accepted/written this cycle
//   o_wrSlot       destination slot for the palette RAM write
//   o_wrBlock      block index within the slot for the current fetch
//   o_missCount    saturating count of accepted misses and upgrades
//
// Fetch handshake: o_memReq acts as "valid" for the address/slot/block
// triple, i_memAck acts as "ready". A block transfers on a rising edge where
// both are high; while o_memReq=1 and i_memAck=0 the triple stays stable.
// i_memAck is ignored when o_memReq=0 and in a cycle where i_flush=1.
// ---------------------------------------------------------------------------
module gpu_clut_slot_cache #(
    parameter int NUM_SLOTS   = 2,
    parameter int BLOCKS_8BPP = 16,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rstGPU,
    input  logic          i_flush,
    input  logic          i_clutReq,
    input  logic [14:0]   i_clutAdr,
    input  logic          i_clutIs8BPP,
    output logic          o_busy,
    output logic          o_ready,
    output logic [SW-1:0] o_slot,
    output logic          o_memReq,
    output logic [14:0]   o_memAdr,
    input  logic          i_memAck,
    output logic [SW-1:0] o_wrSlot,
    output logic [3:0]    o_wrBlock,
    output logic [15:0]   o_missCount
);

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} stateT;

    // Registered state
    stateT                stateQ,     stateD;
    logic [4:0]           blkQ,       blkD;
    logic [4:0]           lastQ,      lastD;
    logic [14:0]          capAdrQ,    capAdrD;
    logic                 capIs8Q,    capIs8D;
    logic [14:0]          tagQ [NUM_SLOTS];
    logic [14:0]          tagD [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] validQ,     validD;
    logic [NUM_SLOTS-1:0] is8Q,       is8D;
    logic [SW-1:0]        rrQ,        rrD;
    logic [SW-1:0]        slotQ,      slotD;
    logic                 readyQ,     readyD;
    logic [15:0]          missCountQ, missCountD;

    // Lookup
    logic [NUM_SLOTS-1:0] matchVec;
    logic [NUM_SLOTS-1:0] hitVec;
    logic [SW-1:0]        hitIdx;
    logic [SW-1:0]        matchIdx;
    logic [SW-1:0]        invIdx;
    logic [SW-1:0]        rrInc;
    logic [SW-1:0]        target;

    function automatic logic [SW-1:0] lowestSet(input logic [NUM_SLOTS-1:0] vec);
        lowestSet = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) lowestSet = SW'(i);
        end
    endfunction

    always_comb begin
        matchVec = '0;
        hitVec   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            matchVec[i] = validQ[i] && (tagQ[i] == i_clutAdr);
            // A full 8bpp palette also satisfies a 4bpp request.
            hitVec[i]   = matchVec[i] && (is8Q[i] || !i_clutIs8BPP);
        end
        hitIdx   = lowestSet(hitVec);
        matchIdx = lowestSet(matchVec);
        invIdx   = lowestSet(~validQ);
        // Explicit wrap keeps NUM_SLOTS=1 (rr is 1 bit wide) pinned at 0.
        rrInc    = (rrQ == SW'(NUM_SLOTS - 1)) ? '0 : rrQ + SW'(1);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rstGPU) begin
        if (i_rstGPU) begin
            stateQ     <= IDLE;
            blkQ       <= '0;
            lastQ      <= '0;
            capAdrQ    <= '0;
            capIs8Q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) tagQ[i] <= '0;
            validQ     <= '0;
            is8Q       <= '0;
            rrQ        <= '0;
            slotQ      <= '0;
            readyQ     <= 1'b0;
            missCountQ <= '0;
        end else begin
            stateQ     <= stateD;
            blkQ       <= blkD;
            lastQ      <= lastD;
            capAdrQ    <= capAdrD;
            capIs8Q    <= capIs8D;
            for (int i = 0; i < NUM_SLOTS; i++) tagQ[i] <= tagD[i];
            validQ     <= validD;
            is8Q       <= is8D;
            rrQ        <= rrD;
            slotQ      <= slotD;
            readyQ     <= readyD;
            missCountQ <= missCountD;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateD     = stateQ;
        blkD       = blkQ;
        lastD      = lastQ;
        capAdrD    = capAdrQ;
        capIs8D    = capIs8Q;
        for (int i = 0; i < NUM_SLOTS; i++) tagD[i] = tagQ[i];
        validD     = validQ;
        is8D       = is8Q;
        rrD        = rrQ;
        slotD      = slotQ;
        readyD     = 1'b0;
        missCountD = missCountQ;
        target     = rrQ;

        if (i_flush) begin
            // Flush beats everything, including a same-cycle request or ack.
            validD = '0;
            rrD    = '0;
            stateD = IDLE;
            blkD   = '0;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (i_clutReq) begin
                        if (hitVec != '0) begin
                            slotD  = hitIdx;
                            readyD = 1'b1;
                        end else begin
                            if (matchVec != '0) begin
                                // Upgrade in place; rr untouched.
                                target = matchIdx;
                            end else if (validQ != '1) begin
                                target = invIdx;
                            end else begin
                                target = rrQ;
                                rrD    = rrInc;
                            end
                            validD[target] = 1'b0;
                            slotD          = target;
                            capAdrD        = i_clutAdr;
                            capIs8D        = i_clutIs8BPP;
                            blkD           = '0;
                            lastD          = i_clutIs8BPP ? 5'(BLOCKS_8BPP - 1) : 5'd0;
                            stateD         = LOAD;
                            if (missCountQ != 16'hFFFF) missCountD = missCountQ + 16'd1;
                        end
                    end
                end
                LOAD: begin
                    if (i_memAck) begin
                        if (blkQ == lastQ) begin
                            tagD[slotQ]   = capAdrQ;
                            is8D[slotQ]   = capIs8Q;
                            validD[slotQ] = 1'b1;
                            readyD        = 1'b1;
                            stateD        = IDLE;
                        end else begin
                            blkD = blkQ + 5'd1;
                        end
                    end
                end
                default: stateD = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded straight from flops, so they are glitch-free and
    // stable while a fetch is waiting for its ack)
    // -----------------------------------------------------------------------
    always_comb begin
        o_busy      = (stateQ == LOAD);
        o_memReq    = (stateQ == LOAD);
        // X base wraps within the row; row bits pass through unchanged.
        o_memAdr    = {capAdrQ[14:6], 6'(capAdrQ[5:0] + {1'b0, blkQ})};
        o_wrSlot    = slotQ;
        o_wrBlock   = blkQ[3:0];
        o_ready     = readyQ;
        o_slot      = slotQ;
        o_missCount = missCountQ;
    end

endmodule

// File: tb/tb_gpu_clut_slot_cache.sv
// ---------------------------------------------------------------------------
// tb_gpu_clut_slot_cache
//
// Directed bench for gpu_clut_slot_cache (NUM_SLOTS=2, BLOCKS_8BPP=16).
// Driver tasks push the expected ready responses {slot, missCount} and the
// expected fetch beats {memAdr, wrBlock, wrSlot} into queues; a monitor on
// the falling edge pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_gpu_clut_slot_cache;

    localparam int SW = 1;

    logic          i_clk;
    logic          i_rstGPU;
    logic          i_flush;
    logic          i_clutReq;
    logic [14:0]   i_clutAdr;
    logic          i_clutIs8BPP;
    logic          o_busy;
    logic          o_ready;
    logic [SW-1:0] o_slot;
    logic          o_memReq;
    logic [14:0]   o_memAdr;
    logic          i_memAck;
    logic [SW-1:0] o_wrSlot;
    logic [3:0]    o_wrBlock;
    logic [15:0]   o_missCount;

    int tests = 0;
    int fails = 0;

    logic [SW+15:0] readyExpQ[$];   // {slot, missCount}
    logic [19:0]    memExpQ[$];     // {memAdr, wrBlock, wrSlot}

    gpu_clut_slot_cache #(.NUM_SLOTS(2), .BLOCKS_8BPP(16)) dut (
        .i_clk        (i_clk),
        .i_rstGPU     (i_rstGPU),
        .i_flush      (i_flush),
        .i_clutReq    (i_clutReq),
        .i_clutAdr    (i_clutAdr),
        .i_clutIs8BPP (i_clutIs8BPP),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_slot       (o_slot),
        .o_memReq     (o_memReq),
        .o_memAdr     (o_memAdr),
        .i_memAck     (i_memAck),
        .o_wrSlot     (o_wrSlot),
        .o_wrBlock    (o_wrBlock),
        .o_missCount  (o_missCount)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        if (!i_rstGPU) begin
            if (o_ready) begin
                tests++;
                if (readyExpQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready: got slot=%0d miss=%0d expected no ready", o_slot, o_missCount);
                end else begin
                    logic [SW+15:0] e;
                    e = readyExpQ.pop_front();
                    if ({o_slot, o_missCount} !== e) begin
                        fails++;
                        $display("FAIL ready_resp: got slot=%0d miss=%0d expected slot=%0d miss=%0d",
                                 o_slot, o_missCount, e[SW+15:16], e[15:0]);
                    end
                end
            end
            if (o_memReq && i_memAck && !i_flush) begin
                tests++;
                if (memExpQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got adr=0x%0h blk=%0d slot=%0d expected no beat",
                             o_memAdr, o_wrBlock, o_wrSlot);
                end else begin
                    logic [19:0] m;
                    m = memExpQ.pop_front();
                    if ({o_memAdr, o_wrBlock, o_wrSlot} !== m) begin
                        fails++;
                        $display("FAIL mem_beat: got adr=0x%0h blk=%0d slot=%0d expected adr=0x%0h blk=%0d slot=%0d",
                                 o_memAdr, o_wrBlock, o_wrSlot, m[19:5], m[4:1], m[0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [14:0] blkAdr(input logic [14:0] adr, input int b);
        logic [5:0] x;
        x = adr[5:0] + 6'(b);
        return {adr[14:6], x};
    endfunction

    task automatic pulseReq(input logic [14:0] adr, input logic is8);
        @(posedge i_clk); #1;
        i_clutReq = 1'b1; i_clutAdr = adr; i_clutIs8BPP = is8;
        @(posedge i_clk); #1;
        i_clutReq = 1'b0;
    endtask

    task automatic ackRun(input logic [14:0] adr, input logic [SW-1:0] slot,
                          input int first, input int count, input int gap);
        for (int b = first; b < first + count; b++) begin
            for (int g = 0; g < gap; g++) begin
                checkVal("stall_memreq", 32'(o_memReq), 32'd1);
                checkVal("stall_memadr", 32'(o_memAdr), 32'(blkAdr(adr, b)));
                @(posedge i_clk); #1;
            end
            memExpQ.push_back({blkAdr(adr, b), 4'(b), slot});
            i_memAck = 1'b1;
            @(posedge i_clk); #1;
            i_memAck = 1'b0;
        end
    endtask

    task automatic reqMiss(input logic [14:0] adr, input logic is8, input logic [SW-1:0] slot,
                           input logic [15:0] mc, input int gap);
        readyExpQ.push_back({slot, mc});
        pulseReq(adr, is8);
        checkVal("miss_busy", 32'(o_busy), 32'd1);
        ackRun(adr, slot, 0, is8 ? 16 : 1, gap);
        checkVal("load_done_ready", 32'(o_ready), 32'd1);
        checkVal("load_done_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic reqHit(input logic [14:0] adr, input logic is8, input logic [SW-1:0] slot,
                          input logic [15:0] mc);
        readyExpQ.push_back({slot, mc});
        pulseReq(adr, is8);
        checkVal("hit_ready", 32'(o_ready), 32'd1);
        checkVal("hit_memreq", 32'(o_memReq), 32'd0);
    endtask

    task automatic doFlush();
        @(posedge i_clk); #1;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rstGPU = 1'b1; i_flush = 1'b0; i_clutReq = 1'b0;
        i_clutAdr = '0; i_clutIs8BPP = 1'b0; i_memAck = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkVal("rst_busy",   32'(o_busy),      32'd0);
        checkVal("rst_ready",  32'(o_ready),     32'd0);
        checkVal("rst_slot",   32'(o_slot),      32'd0);
        checkVal("rst_memreq", 32'(o_memReq),    32'd0);
        checkVal("rst_memadr", 32'(o_memAdr),    32'd0);
        checkVal("rst_wrslot", 32'(o_wrSlot),    32'd0);
        checkVal("rst_wrblk",  32'(o_wrBlock),   32'd0);
        checkVal("rst_miss",   32'(o_missCount), 32'd0);
        i_rstGPU = 1'b0;

        // 4bpp miss with a stalled ack, then a hit
        reqMiss(15'h1234, 1'b0, 1'b0, 16'd1, 2);
        reqHit (15'h1234, 1'b0, 1'b0, 16'd1);

        // 8bpp miss at X=56: wraps 0x00FF -> 0x00C0 in the same row
        reqMiss(15'h00F8, 1'b1, 1'b1, 16'd2, 0);

        // Upgrade in place, rr stays 0 (checked by where C lands)
        doFlush();
        reqMiss(15'h2A05, 1'b0, 1'b0, 16'd3, 0);
        reqMiss(15'h2A05, 1'b1, 1'b0, 16'd4, 0);
        reqHit (15'h2A05, 1'b0, 1'b0, 16'd4);
        reqHit (15'h2A05, 1'b1, 1'b0, 16'd4);
        reqMiss(15'h0882, 1'b0, 1'b1, 16'd5, 0);
        reqMiss(15'h7FFF, 1'b0, 1'b0, 16'd6, 0);

        // Round-robin replacement with two slots
        doFlush();
        reqMiss(15'h0441, 1'b0, 1'b0, 16'd7, 0);   // A -> 0
        reqMiss(15'h0882, 1'b0, 1'b1, 16'd8, 0);   // B -> 1
        reqMiss(15'h7FFF, 1'b0, 1'b0, 16'd9, 0);   // C -> rr=0, rr becomes 1
        reqMiss(15'h0441, 1'b0, 1'b1, 16'd10, 0);  // A -> rr=1, rr becomes 0
        reqHit (15'h0441, 1'b0, 1'b1, 16'd10);
        reqMiss(15'h0882, 1'b0, 1'b0, 16'd11, 0);  // B -> rr=0
        reqHit (15'h0441, 1'b0, 1'b1, 16'd11);

        // Flush at block 5 of an 8bpp load, with an ack in the flush cycle
        doFlush();
        pulseReq(15'h3FC0, 1'b1);                   // miss -> slot 0, count 12
        ackRun(15'h3FC0, 1'b0, 0, 5, 0);
        checkVal("pre_flush_blk", 32'(o_wrBlock), 32'd5);
        i_flush = 1'b1; i_memAck = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;                             // ack stays high: late ack
        checkVal("flush_memreq", 32'(o_memReq), 32'd0);
        checkVal("flush_busy",   32'(o_busy),   32'd0);
        checkVal("flush_slot",   32'(o_slot),   32'd0);
        @(posedge i_clk); #1;
        i_memAck = 1'b0;
        checkVal("late_ack_ready", 32'(o_ready),     32'd0);
        checkVal("late_ack_miss",  32'(o_missCount), 32'd12);
        reqMiss(15'h3FC0, 1'b1, 1'b0, 16'd13, 0);

        // Request while busy is dropped
        doFlush();
        readyExpQ.push_back({1'b0, 16'd14});
        pulseReq(15'h1555, 1'b0);                   // E -> slot 0
        i_clutReq = 1'b1; i_clutAdr = 15'h2AAA; i_clutIs8BPP = 1'b1;
        @(posedge i_clk); #1;
        i_clutReq = 1'b0;
        checkVal("drop_memadr", 32'(o_memAdr),    32'h1555);
        checkVal("drop_miss",   32'(o_missCount), 32'd14);
        ackRun(15'h1555, 1'b0, 0, 1, 0);
        checkVal("drop_load_ready", 32'(o_ready), 32'd1);
        reqHit (15'h1555, 1'b0, 1'b0, 16'd14);
        reqMiss(15'h2AAA, 1'b0, 1'b1, 16'd15, 0);   // dropped F was never cached

        // Flush together with a request in IDLE
        @(posedge i_clk); #1;
        i_flush = 1'b1; i_clutReq = 1'b1; i_clutAdr = 15'h1555; i_clutIs8BPP = 1'b0;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_clutReq = 1'b0;
        checkVal("flushreq_ready", 32'(o_ready),     32'd0);
        checkVal("flushreq_busy",  32'(o_busy),      32'd0);
        checkVal("flushreq_miss",  32'(o_missCount), 32'd15);
        checkVal("flushreq_slot",  32'(o_slot),      32'd1);
        reqMiss(15'h1555, 1'b0, 1'b0, 16'd16, 0);   // all slots were invalidated
        reqMiss(15'h2AAA, 1'b0, 1'b1, 16'd17, 0);

        repeat (3) @(posedge i_clk);
        #1;
        checkVal("ready_q_empty", 32'(readyExpQ.size()), 32'd0);
        checkVal("mem_q_empty",   32'(memExpQ.size()),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
